// File: rtl/fall_game_ctrl.sv
// Game-play sequencer for the lane-catching game: farmer lane, single falling
// object, catch/miss resolution, score/countdown and the Init/Game/Win/Lose FSM.
module fall_game_ctrl #(
  parameter int         LANES     = 8,
  parameter int         FALL_STEP = 8,
  parameter int         CATCH_Y   = 400,
  parameter int         WIN_SCORE = 20,
  parameter int         GAME_TIME = 60,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_pulse,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       tick,
  input  logic       sec_tick,
  output logic [1:0] state,
  output logic [2:0] farmer_x,
  output logic       obj_active,
  output logic [2:0] obj_x,
  output logic [8:0] obj_y,
  output logic [1:0] obj_type,
  output logic [6:0] score,
  output logic [6:0] time_left
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_GAME = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_t;

  localparam logic [2:0] LAST_LANE = 3'(LANES - 1);
  localparam logic [9:0] FALL_10   = 10'(FALL_STEP);
  localparam logic [9:0] CATCH_10  = 10'(CATCH_Y);
  localparam logic [6:0] WIN_7     = 7'(WIN_SCORE);
  localparam logic [6:0] TIME_7    = 7'(GAME_TIME);

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; a nonzero state never maps to zero.
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

  state_t     state_r, state_s;
  logic [2:0] farmer_r, farmer_s;
  logic       obj_active_r, obj_active_s;
  logic [2:0] obj_x_r, obj_x_s;
  logic [8:0] obj_y_r, obj_y_s;
  logic [1:0] obj_type_r, obj_type_s;
  logic [6:0] score_r, score_s;
  logic [6:0] time_r, time_s;
  logic [7:0] lfsr_r, lfsr_s;
  logic [9:0] ny_s;
  logic [7:0] sum_s;
  logic       bug_s, scored_s, timeout_s;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_INIT;
      farmer_r     <= 3'd3;
      obj_active_r <= 1'b0;
      obj_x_r      <= 3'd0;
      obj_y_r      <= 9'd0;
      obj_type_r   <= 2'd0;
      score_r      <= 7'd0;
      time_r       <= TIME_7;
      lfsr_r       <= LFSR_SEED;
    end else begin
      state_r      <= state_s;
      farmer_r     <= farmer_s;
      obj_active_r <= obj_active_s;
      obj_x_r      <= obj_x_s;
      obj_y_r      <= obj_y_s;
      obj_type_r   <= obj_type_s;
      score_r      <= score_s;
      time_r       <= time_s;
      lfsr_r       <= lfsr_s;
    end
  end

  // Next-state and datapath update for the current state and strobes.
  always_comb begin
    state_s      = state_r;
    farmer_s     = farmer_r;
    obj_active_s = obj_active_r;
    obj_x_s      = obj_x_r;
    obj_y_s      = obj_y_r;
    obj_type_s   = obj_type_r;
    score_s      = score_r;
    time_s       = time_r;
    lfsr_s       = lfsr_step(lfsr_r);
    ny_s         = {1'b0, obj_y_r} + FALL_10;
    sum_s        = {1'b0, score_r} + {6'd0, obj_type_r};
    bug_s        = 1'b0;
    scored_s     = 1'b0;
    timeout_s    = 1'b0;

    case (state_r)
      ST_INIT: begin
        if (start_pulse) begin
          state_s      = ST_GAME;
          score_s      = 7'd0;
          time_s       = TIME_7;
          farmer_s     = 3'd3;
          obj_active_s = 1'b0;
          obj_y_s      = 9'd0;
        end else begin
          state_s = ST_INIT;
        end
      end

      ST_GAME: begin
        if (key_left && !key_right && farmer_r != 3'd0) begin
          farmer_s = farmer_r - 3'd1;
        end else if (key_right && !key_left && farmer_r != LAST_LANE) begin
          farmer_s = farmer_r + 3'd1;
        end else begin
          farmer_s = farmer_r;
        end

        if (tick && !obj_active_r) begin
          obj_x_s      = 3'(32'(lfsr_r[2:0]) % LANES);
          obj_type_s   = lfsr_r[4:3];
          obj_y_s      = 9'd0;
          obj_active_s = 1'b1;
        end else if (tick) begin
          if (ny_s < CATCH_10) begin
            obj_y_s = ny_s[8:0];
          end else begin
            obj_active_s = 1'b0;
            obj_y_s      = 9'd0;
            // Compare against the lane held before this edge's movement.
            if (obj_x_r == farmer_r && obj_type_r == 2'd0) begin
              bug_s = 1'b1;
            end else if (obj_x_r == farmer_r) begin
              scored_s = 1'b1;
              score_s  = (sum_s > 8'd99) ? 7'd99 : sum_s[6:0];
            end else begin
              score_s = score_r;
            end
          end
        end else begin
          obj_y_s = obj_y_r;
        end

        if (sec_tick && time_r == 7'd1) begin
          time_s    = 7'd0;
          timeout_s = 1'b1;
        end else if (sec_tick && time_r != 7'd0) begin
          time_s = time_r - 7'd1;
        end else begin
          time_s = time_r;
        end

        // Abort wins over every other outcome and cancels movement/countdown.
        if (start_pulse) begin
          state_s      = ST_INIT;
          farmer_s     = farmer_r;
          score_s      = score_r;
          time_s       = time_r;
          obj_active_s = 1'b0;
          obj_y_s      = 9'd0;
        end else if (bug_s) begin
          state_s = ST_LOSE;
        end else if (scored_s && score_s >= WIN_7) begin
          state_s = ST_WIN;
        end else if (timeout_s) begin
          state_s = ST_LOSE;
        end else begin
          state_s = ST_GAME;
        end
      end

      ST_WIN, ST_LOSE: begin
        if (start_pulse) begin
          state_s = ST_INIT;
        end else begin
          state_s = state_r;
        end
      end

      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  assign state      = state_r;
  assign farmer_x   = farmer_r;
  assign obj_active = obj_active_r;
  assign obj_x      = obj_x_r;
  assign obj_y      = obj_y_r;
  assign obj_type   = obj_type_r;
  assign score      = score_r;
  assign time_left  = time_r;

endmodule

// File: tb/tb_fall_game_ctrl.sv
// Self-checking bench for fall_game_ctrl: a behavioural game model feeds a
// scoreboard each cycle, plus table-driven movement vectors and corner sequences.
module tb_fall_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_pulse = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       tick = 1'b0, sec_tick = 1'b0;
  logic [1:0] state;
  logic [2:0] farmer_x;
  logic       obj_active;
  logic [2:0] obj_x;
  logic [8:0] obj_y;
  logic [1:0] obj_type;
  logic [6:0] score;
  logic [6:0] time_left;

  fall_game_ctrl dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .key_left(key_left),
    .key_right(key_right), .tick(tick), .sec_tick(sec_tick), .state(state),
    .farmer_x(farmer_x), .obj_active(obj_active), .obj_x(obj_x), .obj_y(obj_y),
    .obj_type(obj_type), .score(score), .time_left(time_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [2:0] fx;
    logic       oa;
    logic [2:0] ox;
    logic [8:0] oy;
    logic [1:0] ot;
    logic [6:0] sc;
    logic [6:0] tl;
  } outv_t;

  typedef struct {
    string name;
    outv_t exp;
  } sb_t;

  typedef struct {
    logic l;
    logic r;
    int   exp_fx;
  } mv_t;

  sb_t  sb_q[$];
  int   checks = 0;
  int   failures = 0;

  int         m_state, m_fx, m_oa, m_ox, m_oy, m_ot, m_sc, m_tl;
  logic [7:0] m_lfsr;

  outv_t act;
  assign act = {state, farmer_x, obj_active, obj_x, obj_y, obj_type, score, time_left};

  task automatic model_reset();
    m_state = 0; m_fx = 3; m_oa = 0; m_ox = 0; m_oy = 0; m_ot = 0;
    m_sc = 0; m_tl = 60; m_lfsr = 8'hA5;
  endtask

  function automatic outv_t model_out();
    return {m_state[1:0], m_fx[2:0], m_oa[0], m_ox[2:0], m_oy[8:0], m_ot[1:0],
            m_sc[6:0], m_tl[6:0]};
  endfunction

  // Reference behaviour of one clock edge, written from the game rules.
  task automatic model_update(input logic st, input logic l, input logic r,
                              input logic t, input logic s);
    logic [7:0] cur = m_lfsr;
    int  nfx, nsc, ntl;
    bit  bug = 0, tout = 0;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    if (m_state == 0) begin
      if (st) begin
        m_state = 1; m_sc = 0; m_tl = 60; m_fx = 3; m_oa = 0; m_oy = 0;
      end
    end else if (m_state == 1) begin
      nfx = m_fx; nsc = m_sc; ntl = m_tl;
      if (l && !r && m_fx > 0) nfx = m_fx - 1;
      if (r && !l && m_fx < 7) nfx = m_fx + 1;
      if (t && m_oa == 0) begin
        m_ox = int'(cur[2:0]) % 8; m_ot = int'(cur[4:3]); m_oy = 0; m_oa = 1;
      end else if (t) begin
        if (m_oy + 8 < 400) m_oy = m_oy + 8;
        else begin
          m_oa = 0; m_oy = 0;
          if (m_ox == m_fx) begin
            if (m_ot == 0) bug = 1;
            else nsc = (m_sc + m_ot > 99) ? 99 : m_sc + m_ot;
          end
        end
      end
      if (s) begin
        if (m_tl == 1) begin ntl = 0; tout = 1; end
        else ntl = m_tl - 1;
      end
      if (st) begin
        m_state = 0; m_oa = 0; m_oy = 0;
      end else begin
        m_fx = nfx; m_sc = nsc; m_tl = ntl;
        if (bug) m_state = 3;
        else if (nsc >= 20) m_state = 2;
        else if (tout) m_state = 3;
      end
    end else begin
      if (st) m_state = 0;
    end
  endtask

  task automatic chk(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic sb_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_empty: got no expectation expected one queued");
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  endtask

  // One clock: drive at negedge, queue model expectation, compare at next negedge.
  task automatic step(input logic st, input logic l, input logic r,
                      input logic t, input logic s, input string name);
    start_pulse = st; key_left = l; key_right = r; tick = t; sec_tick = s;
    model_update(st, l, r, t, s);
    sb_q.push_back('{name, model_out()});
    @(posedge clk);
    @(negedge clk);
    sb_check();
    start_pulse = 1'b0; key_left = 1'b0; key_right = 1'b0; tick = 1'b0; sec_tick = 1'b0;
  endtask

  // Wait for an LFSR pattern, spawn, steer the farmer to catch_lane or miss_lane.
  task automatic drop_obj(input int want_x, input int want_t, input int miss_lane);
    int n = 0;
    int tgt;
    while (!((want_x < 0 || int'(m_lfsr[2:0]) == want_x) && int'(m_lfsr[4:3]) == want_t)
           && n < 300) begin
      step(0, 0, 0, 0, 0, "idle");
      n++;
    end
    chk("lfsr_wait_bound", (n < 300) ? 1 : 0, 1);
    step(0, 0, 0, 1, 0, "spawn");
    chk("spawn_active", obj_active, 1);
    chk("spawn_y", obj_y, 0);
    chk("spawn_type", obj_type, want_t);
    if (want_x >= 0) chk("spawn_x", obj_x, want_x);
    tgt = (miss_lane < 0) ? m_ox : miss_lane;
    for (int k = 1; k <= 50; k++) begin
      step(0, m_fx > tgt, m_fx < tgt, 1, 0, "fall");
      if (k == 49) chk("fall_y392", obj_y, 392);
    end
    chk("resolved_inactive", obj_active, 0);
  endtask

  mv_t mv_tab[16];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mv_tab[0]  = '{1'b1, 1'b0, 2};
    mv_tab[1]  = '{1'b1, 1'b0, 1};
    mv_tab[2]  = '{1'b1, 1'b0, 0};
    mv_tab[3]  = '{1'b1, 1'b0, 0};
    for (int i = 0; i < 9; i++) mv_tab[4 + i] = '{1'b0, 1'b1, (i < 7) ? i + 1 : 7};
    mv_tab[13] = '{1'b1, 1'b1, 7};
    mv_tab[14] = '{1'b1, 1'b0, 6};
    mv_tab[15] = '{1'b1, 1'b1, 6};

    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_farmer", farmer_x, 3);
    chk("rst_time", time_left, 60);
    chk("rst_obj", {obj_active, obj_x, obj_y, obj_type, score}, 0);
    rst = 1'b0;

    step(0, 1, 0, 1, 1, "init_ignore");
    step(1, 0, 0, 0, 0, "start");
    chk("start_state", state, 1);
    chk("start_score", score, 0);
    chk("start_time", time_left, 60);
    chk("start_farmer", farmer_x, 3);
    chk("start_obj", obj_active, 0);

    foreach (mv_tab[i]) begin
      step(0, mv_tab[i].l, mv_tab[i].r, 0, 0, "move");
      chk("move_tab", farmer_x, mv_tab[i].exp_fx);
    end

    // Orange in lane 3, caught from lane 3.
    drop_obj(3, 2, -1);
    chk("orange_farmer", farmer_x, 3);
    chk("orange_score", score, 2);
    // Orange in lane 3 with the farmer in lane 5: miss.
    drop_obj(3, 2, 5);
    chk("miss_score", score, 2);
    step(0, 0, 0, 1, 0, "respawn");
    chk("respawn_active", obj_active, 1);
    chk("respawn_y", obj_y, 0);
    step(1, 0, 0, 1, 1, "abort");
    chk("abort_state", state, 0);
    chk("abort_obj", obj_active, 0);
    chk("abort_score_hold", score, 2);

    // Bug caught -> Lose, then frozen.
    step(1, 0, 0, 0, 0, "start2");
    drop_obj(-1, 0, -1);
    chk("bug_lose", state, 3);
    for (int i = 0; i < 4; i++) step(0, i[0], !i[0], 1, 1, "lose_frozen");
    chk("lose_time_frozen", time_left, 60 - 0);
    step(1, 0, 0, 0, 0, "lose_to_init");
    chk("lose_init", state, 0);

    // Six yellows to 18, seventh wins at 21 on the same edge.
    step(1, 0, 0, 0, 0, "start3");
    for (int i = 0; i < 6; i++) drop_obj(-1, 3, -1);
    chk("score18", score, 18);
    chk("score18_state", state, 1);
    drop_obj(-1, 3, -1);
    chk("win_score", score, 21);
    chk("win_state", state, 2);

    // Countdown to timeout.
    step(1, 0, 0, 0, 0, "win_to_init");
    step(1, 0, 0, 0, 0, "start4");
    for (int i = 1; i <= 60; i++) begin
      step(0, 0, 0, 0, 1, "sec");
      if (i == 59) begin
        chk("time_59", time_left, 1);
        chk("state_59", state, 1);
      end
    end
    chk("timeout_time", time_left, 0);
    chk("timeout_state", state, 3);

    // Asynchronous reset mid-game.
    step(1, 0, 0, 0, 0, "to_init5");
    step(1, 0, 0, 0, 0, "start5");
    step(0, 1, 0, 1, 1, "pre_rst");
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_farmer", farmer_x, 3);
    chk("async_rst_time", time_left, 60);
    chk("async_rst_obj", obj_active, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 0, 0, 1, 0, "post_rst_start");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
